// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids and status encodings.
// Imported by fetch, execute, memory and write-back stages.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'h0;
    localparam logic [3:0] IHALT   = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // INS shares code 0 because the status bus is only two bits wide
    typedef enum logic [1:0] {
        SINS = 2'd0,
        SAOK = 2'd1,
        SHLT = 2'd2,
        SADR = 2'd3
    } stat_t;

    function automatic logic is_rnone(input logic [3:0] r);
        return (r == RNONE);
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Architectural register storage: NREG entries, two combinational read ports,
// two write ports where the M port overrides the E port on an index clash.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               NREG     = 15,
    parameter logic [WIDTH-1:0] RSP_INIT = 64'd2040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we_e,
    input  logic [3:0]       i_idx_e,
    input  logic [WIDTH-1:0] i_data_e,
    input  logic             i_we_m,
    input  logic [3:0]       i_idx_m,
    input  logic [WIDTH-1:0] i_data_m,
    input  logic [3:0]       i_idx_a,
    input  logic [3:0]       i_idx_b,
    output logic [WIDTH-1:0] o_rd_a,
    output logic [WIDTH-1:0] o_rd_b
);

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Storage update; index RNONE never matches an entry so it is a natural no-op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (4'(i) == RRSP) ? RSP_INIT : {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i_we_m && (i_idx_m == 4'(i))) begin
                    r_regs[i] <= i_data_m;
                end else if (i_we_e && (i_idx_e == 4'(i))) begin
                    r_regs[i] <= i_data_e;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Read mux built as an OR of one-hot matches, so RNONE reads as zero
    always_comb begin
        w_rd_a = {WIDTH{1'b0}};
        w_rd_b = {WIDTH{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            w_rd_a = w_rd_a | ((i_idx_a == 4'(i)) ? r_regs[i] : {WIDTH{1'b0}});
            w_rd_b = w_rd_b | ((i_idx_b == 4'(i)) ? r_regs[i] : {WIDTH{1'b0}});
        end
    end

    assign o_rd_a = w_rd_a;
    assign o_rd_b = w_rd_b;

endmodule

// File: rtl/writeback_regfile.sv
// SEQ Y86-64 write-back stage: commits valE/valM to the register file,
// tracks sticky processor status and counts retired instructions.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               NREG     = 15,
    parameter logic [WIDTH-1:0] RSP_INIT = 64'd2040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [3:0]       dstE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             dmem_error,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [63:0]      retired
);

    stat_t       r_stat;
    logic        r_halted;
    logic [63:0] r_retired;

    stat_t       w_new_stat;
    logic [3:0]  w_dste_eff;
    logic        w_commit;
    logic        w_we_e;
    logic        w_we_m;

    // Untaken conditional move drops its destination
    assign w_dste_eff = ((icode == ICMOVXX) && !cnd) ? RNONE : dstE;

    // Status of the instruction presented this cycle, fetch faults first
    always_comb begin
        w_new_stat = SAOK;
        if (imem_error) begin
            w_new_stat = SADR;
        end else if (!instr_valid) begin
            w_new_stat = SINS;
        end else if (dmem_error) begin
            w_new_stat = SADR;
        end else if (icode == IHALT) begin
            w_new_stat = SHLT;
        end else begin
            w_new_stat = SAOK;
        end
    end

    assign w_commit = !r_halted && (w_new_stat == SAOK);
    assign w_we_e   = w_commit && !is_rnone(w_dste_eff);
    assign w_we_m   = w_commit && !is_rnone(dstM);

    regfile_2r2w #(
        .WIDTH    (WIDTH),
        .NREG     (NREG),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we_e   (w_we_e),
        .i_idx_e  (w_dste_eff),
        .i_data_e (valE),
        .i_we_m   (w_we_m),
        .i_idx_m  (dstM),
        .i_data_m (valM),
        .i_idx_a  (srcA),
        .i_idx_b  (srcB),
        .o_rd_a   (valA),
        .o_rd_b   (valB)
    );

    // Sticky status and retire counter; everything freezes once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat    <= SAOK;
            r_halted  <= 1'b0;
            r_retired <= 64'd0;
        end else if (!r_halted) begin
            if (w_new_stat == SAOK) begin
                r_stat    <= r_stat;
                r_halted  <= 1'b0;
                r_retired <= r_retired + 64'd1;
            end else begin
                r_stat    <= w_new_stat;
                r_halted  <= 1'b1;
                r_retired <= r_retired;
            end
        end else begin
            r_stat    <= r_stat;
            r_halted  <= r_halted;
            r_retired <= r_retired;
        end
    end

    assign stat    = r_stat;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule
